// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares the core's single data-memory port between two masters.
//   m0 : load/store unit (priority master)
//   m1 : debug / DMA data master (guarded against starvation)
// Fixed priority goes to m0. m1 is forced through after M1_MAX_WAIT
// consecutive refused cycles. A master may lock the port so the two beats
// of a split misaligned access reach memory back-to-back. Load data comes
// back one cycle after the load beat and is steered to the issuing master.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   mX_req_i/gnt_o          beat handshake (transfer on req & gnt)
//   mX_addr_i/data_i        word address and lane-aligned store data
//   mX_wmask_i/wen_i        byte mask, active-low write enable
//   mX_lock_i               next beat of this master must follow directly
//   mX_rvalid_o/rdata_o     load return (rdata always mirrors mem_data_i)
//   mem_*_o                 muxed memory beat, idle values when no grant
//   mem_data_i              memory read data, one cycle after a load beat
module dmem_port_arbiter #(
  parameter int unsigned M1_MAX_WAIT = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  input  logic [3:0]  m0_wmask_i,
  input  logic        m0_wen_i,
  input  logic        m0_lock_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  input  logic [3:0]  m1_wmask_i,
  input  logic        m1_wen_i,
  input  logic        m1_lock_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [3:0]  mem_wmask_o,
  output logic        mem_wen_o,
  input  logic [31:0] mem_data_i
);

  localparam logic [3:0] MAX_WAIT = 4'(M1_MAX_WAIT);

  logic       lock_valid;
  logic       lock_owner;
  logic [3:0] wait_cnt;
  logic       rd_pending;
  logic       rd_owner;

  logic       owner_req;
  logic       lock_hold;
  logic       gnt0;
  logic       gnt1;
  logic       sel_lock;
  logic       sel_wen;

  // Grant decision. A live lock (owner still requesting) beats everything,
  // including the starvation guard; a lock whose owner dropped its request
  // is ignored for this cycle and normal priority applies. Reset blocks all
  // grants regardless of the registered state.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    owner_req = lock_owner ? m1_req_i : m0_req_i;
    lock_hold = lock_valid & owner_req;
    if (!reset_i) begin
      if (lock_hold) begin
        gnt0 = ~lock_owner;
        gnt1 = lock_owner;
      end else if (m1_req_i && (wait_cnt == MAX_WAIT)) begin
        gnt1 = 1'b1;
      end else if (m0_req_i) begin
        gnt0 = 1'b1;
      end else if (m1_req_i) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Memory-side mux of the granted master's beat; idle values otherwise so
  // the memory never sees stale write strobes.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_addr_o  = 32'd0;
    mem_data_o  = 32'd0;
    mem_wmask_o = 4'd0;
    mem_wen_o   = 1'b1;
    sel_lock    = 1'b0;
    sel_wen     = 1'b1;
    if (gnt0) begin
      mem_req_o   = 1'b1;
      mem_addr_o  = m0_addr_i;
      mem_data_o  = m0_data_i;
      mem_wmask_o = m0_wmask_i;
      mem_wen_o   = m0_wen_i;
      sel_lock    = m0_lock_i;
      sel_wen     = m0_wen_i;
    end else if (gnt1) begin
      mem_req_o   = 1'b1;
      mem_addr_o  = m1_addr_i;
      mem_data_o  = m1_data_i;
      mem_wmask_o = m1_wmask_i;
      mem_wen_o   = m1_wen_i;
      sel_lock    = m1_lock_i;
      sel_wen     = m1_wen_i;
    end
  end

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;

  // Load return. The pending flag is masked while reset is held so a load
  // in flight at reset never produces a stray rvalid.
  assign m0_rvalid_o = ~reset_i & rd_pending & ~rd_owner;
  assign m1_rvalid_o = ~reset_i & rd_pending & rd_owner;
  assign m0_rdata_o  = mem_data_i;
  assign m1_rdata_o  = mem_data_i;

  // Registered arbitration state: lock tracking, m1 refusal counter and the
  // one-cycle read-return marker.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lock_valid <= 1'b0;
      lock_owner <= 1'b0;
      wait_cnt   <= 4'd0;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      if (gnt0 || gnt1) begin
        lock_valid <= sel_lock;
        lock_owner <= gnt1;
      end else if (lock_valid && !owner_req) begin
        lock_valid <= 1'b0;
      end

      if (gnt1 || !m1_req_i) begin
        wait_cnt <= 4'd0;
      end else if (wait_cnt != MAX_WAIT) begin
        wait_cnt <= wait_cnt + 4'd1;
      end

      rd_pending <= (gnt0 || gnt1) && sel_wen;
      rd_owner   <= gnt1;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
// Self-checking bench for dmem_port_arbiter: a table of single-beat
// vectors from the reset state, hand-written multi-cycle sequences for the
// lock / starvation / reset corners, and a randomized run compared against
// a behavioural model of the arbitration rules.
module tb_dmem_port_arbiter;

  localparam int MAXW = 4;

  typedef struct {
    bit          rst;
    bit          req  [2];
    logic [31:0] addr [2];
    logic [31:0] data [2];
    logic [3:0]  mask [2];
    bit          wen  [2];
    bit          lock [2];
    logic [31:0] mdata;
  } stim_t;

  typedef struct {
    stim_t       s;
    bit          eg0;
    bit          eg1;
    bit          emreq;
    logic [31:0] eaddr;
    logic [31:0] edata;
    logic [3:0]  emask;
    bit          ewen;
    bit          erv0;
    bit          erv1;
  } vec_t;

  logic        clk;
  logic        reset_i;
  logic        req_v   [2];
  logic [31:0] addr_v  [2];
  logic [31:0] data_v  [2];
  logic [3:0]  mask_v  [2];
  logic        wen_v   [2];
  logic        lock_v  [2];
  logic        gnt_v   [2];
  logic        rvalid_v[2];
  logic [31:0] rdata_v [2];
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_wen_o;
  logic [31:0] mem_data_i;

  int tests = 0;
  int failures = 0;

  dmem_port_arbiter #(.M1_MAX_WAIT(MAXW)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .m0_req_i    (req_v[0]),
    .m0_addr_i   (addr_v[0]),
    .m0_data_i   (data_v[0]),
    .m0_wmask_i  (mask_v[0]),
    .m0_wen_i    (wen_v[0]),
    .m0_lock_i   (lock_v[0]),
    .m0_gnt_o    (gnt_v[0]),
    .m0_rvalid_o (rvalid_v[0]),
    .m0_rdata_o  (rdata_v[0]),
    .m1_req_i    (req_v[1]),
    .m1_addr_i   (addr_v[1]),
    .m1_data_i   (data_v[1]),
    .m1_wmask_i  (mask_v[1]),
    .m1_wen_i    (wen_v[1]),
    .m1_lock_i   (lock_v[1]),
    .m1_gnt_o    (gnt_v[1]),
    .m1_rvalid_o (rvalid_v[1]),
    .m1_rdata_o  (rdata_v[1]),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_wmask_o (mem_wmask_o),
    .mem_wen_o   (mem_wen_o),
    .mem_data_i  (mem_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench always ends on its own.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic stim_t idleStim();
    stim_t s;
    s.rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      s.req[m]  = 1'b0;
      s.addr[m] = 32'd0;
      s.data[m] = 32'd0;
      s.mask[m] = 4'd0;
      s.wen[m]  = 1'b1;
      s.lock[m] = 1'b0;
    end
    s.mdata = 32'd0;
    return s;
  endfunction

  // Drives one cycle's inputs just after the falling edge and waits 1 ns so
  // the combinational outputs can be sampled well away from the rising edge.
  task automatic applyStimulus(input stim_t s);
    @(negedge clk);
    reset_i = s.rst;
    for (int m = 0; m < 2; m++) begin
      req_v[m]  = s.req[m];
      addr_v[m] = s.addr[m];
      data_v[m] = s.data[m];
      mask_v[m] = s.mask[m];
      wen_v[m]  = s.wen[m];
      lock_v[m] = s.lock[m];
    end
    mem_data_i = s.mdata;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic doReset();
    stim_t s;
    s = idleStim();
    s.rst = 1'b1;
    s.req[0] = 1'b1;
    s.req[1] = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    checkOutput("reset_gnt0", 32'(gnt_v[0]), 32'd0);
    checkOutput("reset_gnt1", 32'(gnt_v[1]), 32'd0);
    checkOutput("reset_mem_req", 32'(mem_req_o), 32'd0);
    checkOutput("reset_mem_wen", 32'(mem_wen_o), 32'd1);
    checkOutput("reset_mem_wmask", 32'(mem_wmask_o), 32'd0);
    checkOutput("reset_rvalid0", 32'(rvalid_v[0]), 32'd0);
    checkOutput("reset_rvalid1", 32'(rvalid_v[1]), 32'd0);
  endtask

  function automatic vec_t mkVec(
    input bit r0, input logic [31:0] a0, input bit w0, input logic [3:0] k0, input logic [31:0] d0,
    input bit r1, input logic [31:0] a1, input bit w1, input logic [3:0] k1, input logic [31:0] d1,
    input bit eg0, input bit eg1, input bit emreq, input logic [31:0] eaddr, input logic [31:0] edata,
    input logic [3:0] emask, input bit ewen, input bit erv0, input bit erv1);
    vec_t v;
    v.s = idleStim();
    v.s.req[0] = r0; v.s.addr[0] = a0; v.s.wen[0] = w0; v.s.mask[0] = k0; v.s.data[0] = d0;
    v.s.req[1] = r1; v.s.addr[1] = a1; v.s.wen[1] = w1; v.s.mask[1] = k1; v.s.data[1] = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.emreq = emreq; v.eaddr = eaddr; v.edata = edata;
    v.emask = emask; v.ewen = ewen; v.erv0 = erv0; v.erv1 = erv1;
    return v;
  endfunction

  vec_t vecs[6];

  // Behavioural model state for the random run.
  int    lock_to;
  int    refused;
  int    pend_ld;
  bit    mpend[2];
  stim_t rs;

  initial begin
    stim_t s;
    int g;
    reset_i = 1'b1;
    s = idleStim();
    s.rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      req_v[m] = 1'b0; addr_v[m] = 32'd0; data_v[m] = 32'd0;
      mask_v[m] = 4'd0; wen_v[m] = 1'b1; lock_v[m] = 1'b0;
    end
    mem_data_i = 32'd0;

    // ---------------- table-driven single beats from reset ----------------
    vecs[0] = mkVec(0, 32'h0, 1, 4'h0, 32'h0, 0, 32'h0, 1, 4'h0, 32'h0,
                    0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 0);
    vecs[1] = mkVec(1, 32'h100, 1, 4'hF, 32'h11111111, 0, 32'h0, 1, 4'h0, 32'h0,
                    1, 0, 1, 32'h100, 32'h11111111, 4'hF, 1, 1, 0);
    vecs[2] = mkVec(0, 32'h0, 1, 4'h0, 32'h0, 1, 32'h20, 0, 4'h3, 32'hCAFEF00D,
                    0, 1, 1, 32'h20, 32'hCAFEF00D, 4'h3, 0, 0, 0);
    vecs[3] = mkVec(1, 32'h44, 0, 4'hC, 32'hAAAA5555, 1, 32'h88, 1, 4'hF, 32'h12345678,
                    1, 0, 1, 32'h44, 32'hAAAA5555, 4'hC, 0, 0, 0);
    vecs[4] = mkVec(1, 32'h10, 1, 4'hF, 32'h0, 1, 32'h14, 1, 4'hF, 32'h0,
                    1, 0, 1, 32'h10, 32'h0, 4'hF, 1, 1, 0);
    vecs[5] = mkVec(0, 32'h0, 1, 4'h0, 32'h0, 1, 32'h1234, 1, 4'h0, 32'h0,
                    0, 1, 1, 32'h1234, 32'h0, 4'h0, 1, 0, 1);

    for (int i = 0; i < 6; i++) begin
      doReset();
      applyStimulus(vecs[i].s);
      checkOutput($sformatf("vec%0d_gnt0", i), 32'(gnt_v[0]), 32'(vecs[i].eg0));
      checkOutput($sformatf("vec%0d_gnt1", i), 32'(gnt_v[1]), 32'(vecs[i].eg1));
      checkOutput($sformatf("vec%0d_mem_req", i), 32'(mem_req_o), 32'(vecs[i].emreq));
      checkOutput($sformatf("vec%0d_mem_addr", i), mem_addr_o, vecs[i].eaddr);
      checkOutput($sformatf("vec%0d_mem_data", i), mem_data_o, vecs[i].edata);
      checkOutput($sformatf("vec%0d_mem_wmask", i), 32'(mem_wmask_o), 32'(vecs[i].emask));
      checkOutput($sformatf("vec%0d_mem_wen", i), 32'(mem_wen_o), 32'(vecs[i].ewen));
      s = idleStim();
      s.mdata = 32'h5A5A0000 + 32'(i);
      applyStimulus(s);
      checkOutput($sformatf("vec%0d_rvalid0", i), 32'(rvalid_v[0]), 32'(vecs[i].erv0));
      checkOutput($sformatf("vec%0d_rvalid1", i), 32'(rvalid_v[1]), 32'(vecs[i].erv1));
      checkOutput($sformatf("vec%0d_rdata1", i), rdata_v[1], 32'h5A5A0000 + 32'(i));
    end

    // ---------------- single-master load ----------------
    doReset();
    s = idleStim();
    s.req[0] = 1; s.addr[0] = 32'h100; s.wen[0] = 1; s.mask[0] = 4'hF;
    applyStimulus(s);
    checkOutput("load_gnt0", 32'(gnt_v[0]), 32'd1);
    checkOutput("load_mem_wen", 32'(mem_wen_o), 32'd1);
    s = idleStim();
    s.mdata = 32'hDEADBEEF;
    applyStimulus(s);
    checkOutput("load_rvalid0", 32'(rvalid_v[0]), 32'd1);
    checkOutput("load_rdata0", rdata_v[0], 32'hDEADBEEF);
    checkOutput("load_rvalid1", 32'(rvalid_v[1]), 32'd0);

    // ---------------- priority plus starvation guard ----------------
    doReset();
    s = idleStim();
    s.req[0] = 1; s.addr[0] = 32'h200;
    s.req[1] = 1; s.addr[1] = 32'h300;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(s);
      checkOutput($sformatf("starve_c%0d_gnt0", c), 32'(gnt_v[0]), (c == 4) ? 32'd0 : 32'd1);
      checkOutput($sformatf("starve_c%0d_gnt1", c), 32'(gnt_v[1]), (c == 4) ? 32'd1 : 32'd0);
    end

    // ---------------- misaligned lock against a saturated counter ----------------
    doReset();
    s = idleStim();
    s.req[0] = 1; s.addr[0] = 32'h100;
    s.req[1] = 1; s.addr[1] = 32'h300;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(s);
      checkOutput($sformatf("lock_pre%0d_gnt0", c), 32'(gnt_v[0]), 32'd1);
    end
    s.addr[0] = 32'h103; s.lock[0] = 1;
    applyStimulus(s);
    checkOutput("lock_beat0_gnt0", 32'(gnt_v[0]), 32'd1);
    checkOutput("lock_beat0_addr", mem_addr_o, 32'h103);
    s.addr[0] = 32'h104; s.lock[0] = 0;
    applyStimulus(s);
    checkOutput("lock_beat1_gnt0", 32'(gnt_v[0]), 32'd1);
    checkOutput("lock_beat1_gnt1", 32'(gnt_v[1]), 32'd0);
    checkOutput("lock_beat1_addr", mem_addr_o, 32'h104);
    s.addr[0] = 32'h108;
    applyStimulus(s);
    checkOutput("lock_after_gnt1", 32'(gnt_v[1]), 32'd1);
    checkOutput("lock_after_addr", mem_addr_o, 32'h300);

    // ---------------- lock abandon ----------------
    doReset();
    s = idleStim();
    s.req[0] = 1; s.addr[0] = 32'h400; s.lock[0] = 1;
    applyStimulus(s);
    checkOutput("abandon_c0_gnt0", 32'(gnt_v[0]), 32'd1);
    s = idleStim();
    s.req[1] = 1; s.addr[1] = 32'h500;
    applyStimulus(s);
    checkOutput("abandon_c1_gnt1", 32'(gnt_v[1]), 32'd1);
    checkOutput("abandon_c1_gnt0", 32'(gnt_v[0]), 32'd0);
    // m1 locks, then abandons while m0 asks: m0 must win at once, and a
    // following request pair must go to m0 because no lock is left.
    s = idleStim();
    s.req[1] = 1; s.addr[1] = 32'h504; s.lock[1] = 1;
    applyStimulus(s);
    checkOutput("abandon_m1lock_gnt1", 32'(gnt_v[1]), 32'd1);
    s = idleStim();
    s.req[0] = 1; s.addr[0] = 32'h404;
    applyStimulus(s);
    checkOutput("abandon_m1drop_gnt0", 32'(gnt_v[0]), 32'd1);

    // ---------------- store followed by load ----------------
    doReset();
    s = idleStim();
    s.req[1] = 1; s.addr[1] = 32'h20; s.wen[1] = 0; s.mask[1] = 4'b0011; s.data[1] = 32'hCAFEF00D;
    applyStimulus(s);
    checkOutput("store_gnt1", 32'(gnt_v[1]), 32'd1);
    checkOutput("store_mem_wen", 32'(mem_wen_o), 32'd0);
    checkOutput("store_mem_wmask", 32'(mem_wmask_o), 32'b0011);
    checkOutput("store_mem_data", mem_data_o, 32'hCAFEF00D);
    checkOutput("store_mem_addr", mem_addr_o, 32'h20);
    s = idleStim();
    s.req[0] = 1; s.addr[0] = 32'h40; s.mask[0] = 4'hF;
    applyStimulus(s);
    checkOutput("store_then_load_gnt0", 32'(gnt_v[0]), 32'd1);
    checkOutput("store_no_rvalid1", 32'(rvalid_v[1]), 32'd0);
    checkOutput("store_no_rvalid0", 32'(rvalid_v[0]), 32'd0);
    s = idleStim();
    s.mdata = 32'h0BADF00D;
    applyStimulus(s);
    checkOutput("store_load_rvalid0", 32'(rvalid_v[0]), 32'd1);
    checkOutput("store_load_rvalid1", 32'(rvalid_v[1]), 32'd0);
    checkOutput("store_load_rdata0", rdata_v[0], 32'h0BADF00D);

    // ---------------- reset mid-operation ----------------
    doReset();
    s = idleStim();
    s.req[0] = 1; s.addr[0] = 32'h103; s.lock[0] = 1;
    applyStimulus(s);
    checkOutput("rstmid_gnt0", 32'(gnt_v[0]), 32'd1);
    s.addr[0] = 32'h104; s.lock[0] = 0; s.rst = 1;
    s.req[1] = 1; s.addr[1] = 32'h600;
    applyStimulus(s);
    checkOutput("rstmid_rvalid0", 32'(rvalid_v[0]), 32'd0);
    checkOutput("rstmid_gnt0_low", 32'(gnt_v[0]), 32'd0);
    checkOutput("rstmid_gnt1_low", 32'(gnt_v[1]), 32'd0);
    checkOutput("rstmid_mem_req", 32'(mem_req_o), 32'd0);
    s = idleStim();
    s.req[1] = 1; s.addr[1] = 32'h600;
    applyStimulus(s);
    checkOutput("rstmid_after_gnt1", 32'(gnt_v[1]), 32'd1);
    checkOutput("rstmid_after_rvalid0", 32'(rvalid_v[0]), 32'd0);
    // An m1 lock must not survive reset: afterwards m0 wins by priority.
    s = idleStim();
    s.req[1] = 1; s.addr[1] = 32'h700; s.lock[1] = 1;
    applyStimulus(s);
    checkOutput("rstlock_m1_gnt1", 32'(gnt_v[1]), 32'd1);
    s.rst = 1;
    applyStimulus(s);
    s = idleStim();
    s.req[0] = 1; s.addr[0] = 32'h800;
    s.req[1] = 1; s.addr[1] = 32'h704;
    applyStimulus(s);
    checkOutput("rstlock_after_gnt0", 32'(gnt_v[0]), 32'd1);
    checkOutput("rstlock_after_gnt1", 32'(gnt_v[1]), 32'd0);

    // ---------------- randomized run against the reference model ----------------
    doReset();
    lock_to = -1;
    refused = 0;
    pend_ld = -1;
    mpend[0] = 0;
    mpend[1] = 0;
    rs = idleStim();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rs.rst = ($urandom_range(0, 99) < 3);
      for (int m = 0; m < 2; m++) begin
        if (!mpend[m] && ($urandom_range(0, 99) < 60)) begin
          mpend[m]   = 1;
          rs.addr[m] = $urandom;
          rs.data[m] = $urandom;
          rs.mask[m] = 4'($urandom_range(0, 15));
          rs.wen[m]  = 1'($urandom_range(0, 1));
          rs.lock[m] = ($urandom_range(0, 99) < 35);
        end
        rs.req[m] = mpend[m];
      end
      rs.mdata = $urandom;
      applyStimulus(rs);

      // Who should own the port this cycle.
      if (rs.rst) g = -1;
      else if (lock_to >= 0 && rs.req[lock_to]) g = lock_to;
      else if (rs.req[1] && refused >= MAXW) g = 1;
      else if (rs.req[0]) g = 0;
      else if (rs.req[1]) g = 1;
      else g = -1;

      checkOutput($sformatf("rnd%0d_gnt0", cyc), 32'(gnt_v[0]), 32'(g == 0));
      checkOutput($sformatf("rnd%0d_gnt1", cyc), 32'(gnt_v[1]), 32'(g == 1));
      checkOutput($sformatf("rnd%0d_mem_req", cyc), 32'(mem_req_o), 32'(g >= 0));
      checkOutput($sformatf("rnd%0d_mem_addr", cyc), mem_addr_o, (g >= 0) ? rs.addr[g] : 32'd0);
      checkOutput($sformatf("rnd%0d_mem_data", cyc), mem_data_o, (g >= 0) ? rs.data[g] : 32'd0);
      checkOutput($sformatf("rnd%0d_mem_wmask", cyc), 32'(mem_wmask_o), (g >= 0) ? 32'(rs.mask[g]) : 32'd0);
      checkOutput($sformatf("rnd%0d_mem_wen", cyc), 32'(mem_wen_o), (g >= 0) ? 32'(rs.wen[g]) : 32'd1);
      checkOutput($sformatf("rnd%0d_rvalid0", cyc), 32'(rvalid_v[0]), 32'(!rs.rst && pend_ld == 0));
      checkOutput($sformatf("rnd%0d_rvalid1", cyc), 32'(rvalid_v[1]), 32'(!rs.rst && pend_ld == 1));
      checkOutput($sformatf("rnd%0d_rdata0", cyc), rdata_v[0], rs.mdata);
      checkOutput($sformatf("rnd%0d_rdata1", cyc), rdata_v[1], rs.mdata);

      // Advance the model to the state after this clock edge.
      if (rs.rst) begin
        lock_to = -1;
        refused = 0;
        pend_ld = -1;
      end else begin
        if (g >= 0) lock_to = rs.lock[g] ? g : -1;
        else if (lock_to >= 0 && !rs.req[lock_to]) lock_to = -1;
        if (rs.req[1] && g != 1) refused = (refused + 1 > MAXW) ? MAXW : refused + 1;
        else refused = 0;
        pend_ld = (g >= 0 && rs.wen[g]) ? g : -1;
      end
      if (g >= 0) mpend[g] = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
